// File: rtl/tmds_serializer.sv
// TMDS 10:1 serializer for the DVI PMOD: shifts three data words plus the clock
// pattern out LSB first on the bit clock, requesting words and covering underruns.
module tmds_serializer #(
  parameter logic [9:0]  CLK_PATTERN = 10'b0000011111,
  parameter logic [9:0]  IDLE_TOKEN  = 10'b1101010100,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       tmds_red,
  input  logic [9:0]       tmds_green,
  input  logic [9:0]       tmds_blue,
  input  logic             word_valid,
  input  logic             underrun_clr,
  output logic             word_req,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [7:0]       tmds
);

  localparam int unsigned WORD_W = 10;
  localparam int unsigned BIT_W  = 4;
  localparam logic [BIT_W-1:0] LAST_BIT = 4'd9;
  // Registered request lands in the bit_cnt==8 cycle.
  localparam logic [BIT_W-1:0] REQ_BIT  = 4'd7;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [BIT_W-1:0]  bit_cnt;
  logic              load_c;
  logic [WORD_W-1:0] sr_clk, sr_red, sr_green, sr_blue;
  logic [WORD_W-1:0] nxt_clk_c, nxt_red_c, nxt_green_c, nxt_blue_c;
  logic              clk_n, red_n, green_n, blue_n;
  logic              flag_nxt_c;
  logic [CNT_W-1:0]  cnt_base_c, cnt_nxt_c;

  assign load_c = (bit_cnt == LAST_BIT);

  // Slot position counter and the word request strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      word_req <= 1'b0;
    end else begin
      bit_cnt  <= load_c ? '0 : bit_cnt + BIT_W'(1);
      word_req <= (bit_cnt == REQ_BIT);
    end
  end

  // Shift-register next state: load a fresh slot or shift toward bit 0.
  always_comb begin
    nxt_clk_c   = {1'b0, sr_clk[WORD_W-1:1]};
    nxt_red_c   = {1'b0, sr_red[WORD_W-1:1]};
    nxt_green_c = {1'b0, sr_green[WORD_W-1:1]};
    nxt_blue_c  = {1'b0, sr_blue[WORD_W-1:1]};
    if (load_c) begin
      nxt_clk_c   = CLK_PATTERN;
      nxt_red_c   = word_valid ? tmds_red   : IDLE_TOKEN;
      nxt_green_c = word_valid ? tmds_green : IDLE_TOKEN;
      nxt_blue_c  = word_valid ? tmds_blue  : IDLE_TOKEN;
    end
  end

  // The _n flops take the complement of the next bit 0 so p and n toggle together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_clk   <= '0;
      sr_red   <= '0;
      sr_green <= '0;
      sr_blue  <= '0;
      clk_n    <= 1'b1;
      red_n    <= 1'b1;
      green_n  <= 1'b1;
      blue_n   <= 1'b1;
    end else begin
      sr_clk   <= nxt_clk_c;
      sr_red   <= nxt_red_c;
      sr_green <= nxt_green_c;
      sr_blue  <= nxt_blue_c;
      clk_n    <= ~nxt_clk_c[0];
      red_n    <= ~nxt_red_c[0];
      green_n  <= ~nxt_green_c[0];
      blue_n   <= ~nxt_blue_c[0];
    end
  end

  assign tmds = {sr_clk[0], clk_n, sr_red[0], red_n,
                 sr_green[0], green_n, sr_blue[0], blue_n};

  // Underrun tracking: a clear is applied first so a coincident underrun still counts once.
  always_comb begin
    cnt_base_c = underrun_clr ? '0 : underrun_cnt;
    flag_nxt_c = underrun_clr ? 1'b0 : underrun;
    cnt_nxt_c  = cnt_base_c;
    if (load_c && !word_valid) begin
      flag_nxt_c = 1'b1;
      if (cnt_base_c != CNT_MAX) cnt_nxt_c = cnt_base_c + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun     <= flag_nxt_c;
      underrun_cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed bench for tmds_serializer: reset, data path, clock channel, underrun,
// saturation, clear collision and mid-word reset.
module tb_tmds_serializer;

  localparam logic [9:0] CLK_PAT  = 10'b0000011111;
  localparam logic [9:0] IDLE_TOK = 10'b1101010100;
  localparam logic [9:0] REQ_PAT  = 10'b0100000000;

  logic       clk;
  logic       rst;
  logic [9:0] tmds_red, tmds_green, tmds_blue;
  logic       word_valid, underrun_clr;
  logic       word_req, underrun;
  logic [7:0] underrun_cnt;
  logic [7:0] tmds;

  int checks   = 0;
  int failures = 0;

  tmds_serializer #(.CLK_PATTERN(CLK_PAT), .IDLE_TOKEN(IDLE_TOK), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .tmds_red(tmds_red), .tmds_green(tmds_green), .tmds_blue(tmds_blue),
    .word_valid(word_valid), .underrun_clr(underrun_clr),
    .word_req(word_req), .underrun(underrun), .underrun_cnt(underrun_cnt),
    .tmds(tmds)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at the negedge of a bit_cnt==9 cycle; drives a slot and captures the
  // ten serial bits that follow the load edge, ending on the next bit_cnt==9 negedge.
  task automatic run_slot(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                          input logic v, input string tag);
    logic [9:0] cp, cn, rp, rn, gp, gn, bp, bn, rq;
    logic [9:0] er, eg, eb;
    tmds_red = r; tmds_green = g; tmds_blue = b; word_valid = v;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cp[k] = tmds[7]; cn[k] = tmds[6];
      rp[k] = tmds[5]; rn[k] = tmds[4];
      gp[k] = tmds[3]; gn[k] = tmds[2];
      bp[k] = tmds[1]; bn[k] = tmds[0];
      rq[k] = word_req;
    end
    er = v ? r : IDLE_TOK;
    eg = v ? g : IDLE_TOK;
    eb = v ? b : IDLE_TOK;
    checks++; if (rp !== er)      begin failures++; $display("FAIL %s red_p got=%b exp=%b", tag, rp, er); end
    checks++; if (rn !== ~er)     begin failures++; $display("FAIL %s red_n got=%b exp=%b", tag, rn, ~er); end
    checks++; if (gp !== eg)      begin failures++; $display("FAIL %s green_p got=%b exp=%b", tag, gp, eg); end
    checks++; if (gn !== ~eg)     begin failures++; $display("FAIL %s green_n got=%b exp=%b", tag, gn, ~eg); end
    checks++; if (bp !== eb)      begin failures++; $display("FAIL %s blue_p got=%b exp=%b", tag, bp, eb); end
    checks++; if (bn !== ~eb)     begin failures++; $display("FAIL %s blue_n got=%b exp=%b", tag, bn, ~eb); end
    checks++; if (cp !== CLK_PAT) begin failures++; $display("FAIL %s clk_p got=%b exp=%b", tag, cp, CLK_PAT); end
    checks++; if (cn !== ~CLK_PAT) begin failures++; $display("FAIL %s clk_n got=%b exp=%b", tag, cn, ~CLK_PAT); end
    checks++; if (rq !== REQ_PAT) begin failures++; $display("FAIL %s word_req got=%b exp=%b", tag, rq, REQ_PAT); end
  endtask

  // Samples the ten cycles after reset release: all p low, request only at cycle 8.
  task automatic check_post_reset(input string tag);
    logic [9:0] rq;
    logic       bad_tmds;
    bad_tmds = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rq[k] = word_req;
      if (tmds !== 8'b01010101) bad_tmds = 1'b1;
    end
    checks++; if (bad_tmds) begin failures++; $display("FAIL %s idle_tmds last=%b exp=01010101", tag, tmds); end
    checks++; if (rq !== REQ_PAT) begin failures++; $display("FAIL %s first_req got=%b exp=%b", tag, rq, REQ_PAT); end
  endtask

  task automatic check_underrun(input logic ef, input logic [7:0] ec, input string tag);
    checks++; if (underrun !== ef) begin failures++; $display("FAIL %s underrun got=%b exp=%b", tag, underrun, ef); end
    checks++; if (underrun_cnt !== ec) begin failures++; $display("FAIL %s underrun_cnt got=%0d exp=%0d", tag, underrun_cnt, ec); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tmds_red = '0; tmds_green = '0; tmds_blue = '0;
    word_valid = 1'b1; underrun_clr = 1'b0;
    #2;
    checks++; if (tmds !== 8'b01010101) begin failures++; $display("FAIL reset_tmds got=%b exp=01010101", tmds); end
    checks++; if (word_req !== 1'b0) begin failures++; $display("FAIL reset_word_req got=%b exp=0", word_req); end
    check_underrun(1'b0, 8'd0, "reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_post_reset("reset_release");
  endtask

  task automatic test_datapath();
    run_slot(10'b1010011100, 10'b0110110001, 10'b1111000010, 1'b1, "datapath");
    check_underrun(1'b0, 8'd0, "datapath");
  endtask

  task automatic test_clock();
    run_slot(10'b0000000000, 10'b1111111111, 10'b0101010101, 1'b1, "clock0");
    run_slot(10'b1111111111, 10'b0000000000, 10'b1010101010, 1'b1, "clock1");
    run_slot(10'b1000000001, 10'b0111111110, 10'b0011001100, 1'b1, "clock2");
    run_slot(10'b0100100100, 10'b1011011011, 10'b1100110011, 1'b1, "clock3");
    run_slot(10'b0000011111, 10'b1111100000, 10'b1001001001, 1'b1, "clock4");
  endtask

  task automatic test_underrun();
    run_slot(10'b1010011100, 10'b0110110001, 10'b1111000010, 1'b0, "underrun_slot");
    check_underrun(1'b1, 8'd1, "underrun_slot");
    run_slot(10'b1010011100, 10'b0110110001, 10'b1111000010, 1'b1, "after_underrun");
    check_underrun(1'b1, 8'd1, "after_underrun");
  endtask

  task automatic test_saturation();
    word_valid = 1'b0;
    repeat (253 * 10) @(negedge clk);
    check_underrun(1'b1, 8'd254, "sat_254");
    repeat (10) @(negedge clk);
    check_underrun(1'b1, 8'd255, "sat_255");
    repeat (46 * 10) @(negedge clk);
    check_underrun(1'b1, 8'd255, "sat_hold");
  endtask

  task automatic test_clear();
    word_valid = 1'b1; underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check_underrun(1'b0, 8'd0, "clr_valid_load");
    repeat (9) @(negedge clk);
    word_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_underrun(1'b1, 8'd1, "clr_setup");
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0; word_valid = 1'b1;
    check_underrun(1'b1, 8'd1, "clr_invalid_load");
    repeat (9) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    tmds_red = 10'b1111111111; tmds_green = 10'b1111111111; tmds_blue = 10'b1111111111;
    word_valid = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (tmds !== 8'b01010101) begin failures++; $display("FAIL midrst_tmds got=%b exp=01010101", tmds); end
    checks++; if (word_req !== 1'b0) begin failures++; $display("FAIL midrst_word_req got=%b exp=0", word_req); end
    check_underrun(1'b0, 8'd0, "midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_post_reset("midrst_release");
    run_slot(10'b1010011100, 10'b0110110001, 10'b1111000010, 1'b1, "midrst_restart");
    check_underrun(1'b0, 8'd0, "midrst_restart");
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_clock();
    test_underrun();
    test_saturation();
    test_clear();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
